fas_stream_checker: RTL and testbench

FAS_STREAM_CHECKER -- requirements
Module: fas_stream_checker

---
 rtl/fas_stream_checker.sv | 182 ++++++++++++++++++
 tb/tb_fas_stream_checker.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fas_stream_checker.sv
// Lane-wise stream checker: compares DUT beats against a FIFO-buffered golden stream with wrap-around tolerance.
// Optional first-error capture ports are built when FAS_CHK_ERRLOG_EN is defined.
module fas_stream_checker #(
  parameter int DATA_W     = 16,
  parameter int LANES      = 16,
  parameter int TOL        = 3,
  parameter int NUM_BEATS  = 64,
  parameter int FAIL_LIMIT = 48,
  parameter int GDEPTH     = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic                             gold_valid,
  input  logic [LANES*DATA_W-1:0]          gold_data,
  output logic                             gold_ready,
  input  logic                             dut_valid,
  input  logic [LANES*DATA_W-1:0]          dut_data,
  output logic                             busy,
  output logic                             done,
  output logic                             pass,
  output logic [$clog2(FAIL_LIMIT+1)-1:0]  fail_cnt,
  output logic [$clog2(NUM_BEATS+1)-1:0]   beat_cnt,
  output logic                             underflow
`ifdef FAS_CHK_ERRLOG_EN
  ,
  output logic                             err_valid,
  output logic [$clog2(NUM_BEATS)-1:0]     err_beat,
  output logic [$clog2(LANES)-1:0]         err_lane,
  output logic [DATA_W-1:0]                err_dut,
  output logic [DATA_W-1:0]                err_gold
`endif
);

  localparam int FC_W = $clog2(FAIL_LIMIT+1);
  localparam int BC_W = $clog2(NUM_BEATS+1);
  localparam int AW   = $clog2(GDEPTH);
  localparam int MW   = $clog2(LANES+1);
  localparam int SW   = FC_W + MW + 1;
  localparam logic [DATA_W-1:0] TOL_V = DATA_W'(TOL);

  typedef enum logic [1:0] {IDLE, RUN, ABORT, FIN} state_t;
  state_t state, state_nxt;

  logic [LANES*DATA_W-1:0] mem [GDEPTH];
  logic [AW-1:0]           wr_ptr, rd_ptr;
  logic [AW:0]             level;
  logic                    fifo_empty, fifo_full, push, pop;
  logic                    beat, beat_uf, start_go, hit_limit, last_beat;
  logic [LANES*DATA_W-1:0] gold_head;
  logic [LANES-1:0]        lane_bad;
  logic [MW-1:0]           beat_mism;
  logic [SW-1:0]           fail_sum;
  logic [FC_W-1:0]         fail_nxt;

  assign fifo_empty = (level == '0);
  assign fifo_full  = (level == (AW+1)'(GDEPTH));
  assign busy       = (state == RUN);
  assign gold_ready = busy && !fifo_full;
  assign push       = gold_valid && gold_ready;
  assign beat       = busy && dut_valid;
  assign beat_uf    = beat && fifo_empty;
  assign pop        = beat && !fifo_empty;
  assign start_go   = start && ((state == IDLE) || (state == FIN));
  assign gold_head  = mem[rd_ptr];

  // Both modular differences exceeding TOL means the lane is outside the wrap-around window.
  for (genvar n = 0; n < LANES; n++) begin : g_lane
    logic [DATA_W-1:0] diff, ndiff;
    assign diff        = dut_data[n*DATA_W +: DATA_W] - gold_head[n*DATA_W +: DATA_W];
    assign ndiff       = gold_head[n*DATA_W +: DATA_W] - dut_data[n*DATA_W +: DATA_W];
    assign lane_bad[n] = (diff > TOL_V) && (ndiff > TOL_V);
  end

  always_comb begin
    beat_mism = '0;
    if (beat_uf) begin
      beat_mism = MW'(LANES);
    end else begin
      for (int n = 0; n < LANES; n++) beat_mism = beat_mism + MW'(lane_bad[n]);
    end
  end

  assign fail_sum  = SW'(fail_cnt) + SW'(beat_mism);
  assign hit_limit = (fail_sum >= SW'(FAIL_LIMIT));
  assign fail_nxt  = hit_limit ? FC_W'(FAIL_LIMIT) : fail_sum[FC_W-1:0];
  assign last_beat = (beat_cnt == BC_W'(NUM_BEATS-1));

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, FIN: if (start) state_nxt = RUN;
      RUN: begin
        if (beat) begin
          if (hit_limit)      state_nxt = ABORT;
          else if (last_beat) state_nxt = FIN;
        end
      end
      ABORT:   state_nxt = ABORT;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= gold_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail_cnt  <= '0;
      beat_cnt  <= '0;
      underflow <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
    end else begin
      state <= state_nxt;
      done  <= 1'b0;
      if (start_go) begin
        pass      <= 1'b0;
        fail_cnt  <= '0;
        beat_cnt  <= '0;
        underflow <= 1'b0;
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        level     <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        if (push && !pop)      level <= level + (AW+1)'(1);
        else if (!push && pop) level <= level - (AW+1)'(1);
        if (beat) begin
          fail_cnt <= fail_nxt;
          beat_cnt <= beat_cnt + BC_W'(1);
          if (beat_uf) underflow <= 1'b1;
          if (hit_limit) begin
            done <= 1'b1;
            pass <= 1'b0;
          end else if (last_beat) begin
            done <= 1'b1;
            pass <= (fail_nxt == '0) && !underflow && !beat_uf;
          end
        end
      end
    end
  end

`ifdef FAS_CHK_ERRLOG_EN
  localparam int LW = $clog2(LANES);
  localparam int EB = $clog2(NUM_BEATS);
  logic [LW-1:0] first_lane, sel_lane;

  // Descending scan leaves the lowest failing lane selected; underflow logs lane 0 with gold 0.
  always_comb begin
    first_lane = '0;
    for (int n = LANES-1; n >= 0; n--) begin
      if (lane_bad[n]) first_lane = LW'(n);
    end
    sel_lane = beat_uf ? '0 : first_lane;
  end

  always_ff @(posedge clk) begin
    if (rst || start_go) begin
      err_valid <= 1'b0;
      err_beat  <= '0;
      err_lane  <= '0;
      err_dut   <= '0;
      err_gold  <= '0;
    end else if (beat && (beat_mism != '0) && !err_valid) begin
      err_valid <= 1'b1;
      err_beat  <= EB'(beat_cnt);
      err_lane  <= sel_lane;
      err_dut   <= dut_data[sel_lane*DATA_W +: DATA_W];
      err_gold  <= beat_uf ? '0 : gold_head[sel_lane*DATA_W +: DATA_W];
    end
  end
`endif

endmodule

// File: tb/tb_fas_stream_checker.sv
// Scoreboard bench for fas_stream_checker: a queue-based reference model predicts status and run results.
`timescale 1ns/1ps
module tb_fas_stream_checker;
  localparam int DW = 16, LN = 16, TOLP = 3, NB = 4, FL = 48, GD = 4;
  localparam int BW  = LN*DW;
  localparam int FCW = $clog2(FL+1);
  localparam int BCW = $clog2(NB+1);

  logic          clk = 1'b0;
  logic          rst, start, gold_valid, dut_valid;
  logic [BW-1:0] gold_data, dut_data;
  logic          gold_ready, busy, done, pass, underflow;
  logic [FCW-1:0] fail_cnt;
  logic [BCW-1:0] beat_cnt;
`ifdef FAS_CHK_ERRLOG_EN
  logic                   err_valid;
  logic [$clog2(NB)-1:0]  err_beat;
  logic [$clog2(LN)-1:0]  err_lane;
  logic [DW-1:0]          err_dut, err_gold;
`endif

  fas_stream_checker #(.DATA_W(DW), .LANES(LN), .TOL(TOLP), .NUM_BEATS(NB),
                       .FAIL_LIMIT(FL), .GDEPTH(GD)) dut (
    .clk(clk), .rst(rst), .start(start), .gold_valid(gold_valid), .gold_data(gold_data),
    .gold_ready(gold_ready), .dut_valid(dut_valid), .dut_data(dut_data), .busy(busy),
    .done(done), .pass(pass), .fail_cnt(fail_cnt), .beat_cnt(beat_cnt), .underflow(underflow)
`ifdef FAS_CHK_ERRLOG_EN
    , .err_valid(err_valid), .err_beat(err_beat), .err_lane(err_lane),
    .err_dut(err_dut), .err_gold(err_gold)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int fail; int beats; bit pass; bit uf;
    bit errv; int eb; int el; int ed; int eg;
  } exp_t;

  logic [BW-1:0] mq[$];
  exp_t          expq[$];
  exp_t          e;
  bit            m_run, m_abort, m_done, m_pass, m_uf, m_rst, mon_en;
  bit            was_idle, acc, uf_now;
  int            m_fail, m_beats, m_pushes, m_cnt, first_m;
  bit            m_errv;
  int            m_eb, m_el, m_ed, m_eg;
  logic [BW-1:0] g_m;

  function automatic bit lane_ok(int d, int g);
    int diff;
    diff = (d - g) & ((1 << DW) - 1);
    return (diff <= TOLP) || (diff >= (1 << DW) - TOLP);
  endfunction

  task automatic model_clear();
    m_pass = 0; m_uf = 0; m_fail = 0; m_beats = 0;
    m_errv = 0; m_eb = 0; m_el = 0; m_ed = 0; m_eg = 0;
    mq.delete();
  endtask

  always @(posedge clk) begin
    m_done = 0;
    m_rst  = 0;
    if (rst) begin
      model_clear();
      m_run = 0; m_abort = 0; m_rst = 1;
    end else begin
      was_idle = !m_run && !m_abort;
      acc = m_run && gold_valid && (mq.size() < GD);
      if (m_run && dut_valid) begin
        m_cnt = 0; first_m = -1; uf_now = (mq.size() == 0);
        if (uf_now) begin
          m_cnt = LN; first_m = 0; g_m = '0;
        end else begin
          g_m = mq.pop_front();
          for (int n = 0; n < LN; n++) begin
            if (!lane_ok(int'(dut_data[n*DW +: DW]), int'(g_m[n*DW +: DW]))) begin
              m_cnt++;
              if (first_m < 0) first_m = n;
            end
          end
        end
        if (m_cnt > 0 && !m_errv) begin
          m_errv = 1; m_eb = m_beats; m_el = first_m;
          m_ed = int'(dut_data[first_m*DW +: DW]);
          m_eg = uf_now ? 0 : int'(g_m[first_m*DW +: DW]);
        end
        if (uf_now) m_uf = 1;
        m_fail = (m_fail + m_cnt > FL) ? FL : m_fail + m_cnt;
        m_beats++;
        if (m_fail == FL) begin
          m_run = 0; m_abort = 1; m_done = 1; m_pass = 0;
        end else if (m_beats == NB) begin
          m_run = 0; m_done = 1; m_pass = (m_fail == 0) && !m_uf;
        end
        if (m_done) expq.push_back('{m_fail, m_beats, m_pass, m_uf, m_errv, m_eb, m_el, m_ed, m_eg});
      end
      if (acc) begin
        mq.push_back(gold_data);
        m_pushes++;
      end
      if (was_idle && start) begin
        model_clear();
        m_run = 1;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (mon_en) begin
      chk("status", {busy, gold_ready, done, pass, underflow, fail_cnt, beat_cnt},
          {m_run, m_run && (mq.size() < GD), m_done, m_pass, m_uf, FCW'(m_fail), BCW'(m_beats)});
      if (m_rst)
        chk("reset_state", {busy, gold_ready, done, pass, underflow, fail_cnt, beat_cnt}, 64'd0);
`ifdef FAS_CHK_ERRLOG_EN
      chk("errlog", {err_valid, err_beat, err_lane, err_dut, err_gold},
          {m_errv, 2'(m_eb), 4'(m_el), 16'(m_ed), 16'(m_eg)});
`endif
      chk("done_expected", done, expq.size() != 0);
      if (done && expq.size() != 0) begin
        e = expq.pop_front();
        chk("done_fail_cnt", fail_cnt, e.fail);
        chk("done_beat_cnt", beat_cnt, e.beats);
        chk("done_pass", pass, e.pass);
        chk("done_underflow", underflow, e.uf);
      end else if (expq.size() != 0) begin
        expq.delete();
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [BW-1:0] gs[$], ds[$];
  int run_base;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1; tick(); rst = 0;
  endtask

  task automatic pulse_start();
    start = 1; tick(); start = 0;
  endtask

  function automatic logic [BW-1:0] put(logic [BW-1:0] v, int n, logic [DW-1:0] x);
    v[n*DW +: DW] = x;
    return v;
  endfunction

  function automatic logic [BW-1:0] rand_beat();
    logic [BW-1:0] v;
    for (int n = 0; n < LN; n++) begin
      case ($urandom_range(0, 9))
        0:       v[n*DW +: DW] = DW'(16'hFFFF - $urandom_range(0, 3));
        1:       v[n*DW +: DW] = DW'($urandom_range(0, 3));
        default: v[n*DW +: DW] = DW'($urandom);
      endcase
    end
    return v;
  endfunction

  task automatic drive_gold(input int gap_max);
    int base, k;
    for (int i = 0; i < gs.size(); i++) begin
      gold_valid = 1; gold_data = gs[i];
      base = m_pushes; k = 0;
      while (m_pushes == base && k < 100) begin tick(); k++; end
      if (k >= 100) chk("gold_accept_timeout", 64'(m_pushes - base), 64'd1);
      gold_valid = 0;
      repeat ($urandom_range(0, gap_max)) tick();
    end
  endtask

  task automatic drive_dut(input int gap_max, input int delay, input bit need_gold);
    int k;
    repeat (delay) tick();
    if (gs.size() > GD) chk("full_gold_ready", gold_ready, 1'b0);
    for (int i = 0; i < ds.size(); i++) begin
      k = 0;
      while (need_gold && (m_pushes - run_base <= i) && k < 200) begin tick(); k++; end
      if (k >= 200) chk("gold_wait_timeout", 64'(m_pushes - run_base), 64'(i + 1));
      dut_valid = 1; dut_data = ds[i];
      tick();
      dut_valid = 0;
      repeat ($urandom_range(0, gap_max)) tick();
    end
  endtask

  task automatic run(input int ggap, input int dgap, input int delay, input bit need_gold);
    pulse_start();
    run_base = m_pushes;
    fork
      drive_gold(ggap);
      drive_dut(dgap, delay, need_gold);
    join
    repeat (3) tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1);
  end

  initial begin
    logic [BW-1:0] v, w;
    int d;
    rst = 1; start = 0; gold_valid = 0; dut_valid = 0; gold_data = '0; dut_data = '0;
    tick();
    mon_en = 1;
    tick();
    rst = 0;
    tick();

    // Matching run with golden one beat ahead.
    gs.delete(); ds.delete();
    for (int i = 0; i < NB; i++) begin v = rand_beat(); gs.push_back(v); ds.push_back(v); end
    run(0, 0, 1, 1);
    chk("match_pass", pass, 1'b1);
    chk("match_fail_cnt", fail_cnt, 0);

    // +3 on lane 5 (ok), -4 across zero on lane 2 (bad).
    gs.delete(); ds.delete();
    for (int i = 0; i < NB; i++) begin v = rand_beat(); gs.push_back(v); ds.push_back(v); end
    ds[0] = put(ds[0], 5, gs[0][5*DW +: DW] + 16'd3);
    gs[1] = put(gs[1], 2, 16'h0000);
    ds[1] = put(ds[1], 2, 16'hFFFC);
    run(1, 1, 0, 1);
    chk("tol_fail_cnt", fail_cnt, 1);
    chk("tol_pass", pass, 1'b0);
`ifdef FAS_CHK_ERRLOG_EN
    chk("tol_err_beat", err_beat, 1);
    chk("tol_err_lane", err_lane, 2);
`endif

    // Wrap-around: gold 0xFFFF, dut 0x0002.
    gs.delete(); ds.delete();
    for (int i = 0; i < NB; i++) begin v = rand_beat(); gs.push_back(v); ds.push_back(v); end
    gs[2] = put(gs[2], 7, 16'hFFFF);
    ds[2] = put(ds[2], 7, 16'h0002);
    run(0, 2, 2, 1);
    chk("wrap_fail_cnt", fail_cnt, 0);
    chk("wrap_pass", pass, 1'b1);

    // All lanes wrong: abort after third beat, fourth beat ignored.
    gs.delete(); ds.delete();
    for (int i = 0; i < NB; i++) begin
      v = rand_beat(); gs.push_back(v);
      w = '0;
      for (int n = 0; n < LN; n++) w[n*DW +: DW] = v[n*DW +: DW] ^ 16'h8000;
      ds.push_back(w);
    end
    run(0, 0, 6, 1);
    chk("abort_fail_cnt", fail_cnt, FL);
    chk("abort_beat_cnt", beat_cnt, 3);
    chk("abort_pass", pass, 1'b0);
    chk("abort_busy", busy, 1'b0);
    do_reset();

    // FIFO full with gold_valid held, then back-to-back beats.
    gs.delete(); ds.delete();
    for (int i = 0; i < 6; i++) begin v = rand_beat(); gs.push_back(v); if (i < NB) ds.push_back(v); end
    run(0, 0, 8, 1);
    chk("full_pass", pass, 1'b1);
    chk("full_fail_cnt", fail_cnt, 0);

    // Underflow, then reset mid-run with one beat buffered.
    gs.delete(); ds.delete();
    ds.push_back(rand_beat());
    run(0, 0, 0, 0);
    chk("uf_flag", underflow, 1'b1);
    chk("uf_fail_cnt", fail_cnt, LN);
    gold_valid = 1; gold_data = rand_beat(); tick(); gold_valid = 0;
    do_reset();
    chk("rst_outputs", {busy, done, pass, underflow, gold_ready, fail_cnt, beat_cnt}, 64'd0);

    // Randomised runs.
    for (int r = 0; r < 25; r++) begin
      if ($urandom_range(0, 3) == 0) do_reset();
      gs.delete(); ds.delete();
      for (int i = 0; i < NB; i++) begin
        v = rand_beat(); gs.push_back(v); w = v;
        for (int n = 0; n < LN; n++) begin
          if ($urandom_range(0, 99) < 88) d = int'($urandom_range(0, 6)) - 3;
          else d = int'($urandom_range(4, 40)) * ($urandom_range(0, 1) ? 1 : -1);
          w[n*DW +: DW] = DW'(int'(v[n*DW +: DW]) + d);
        end
        ds.push_back(w);
      end
      run($urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 3), 1);
    end

    repeat (3) tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
